// File: rtl/pipe_hazard_pkg.sv
// Shared types and helpers for the pipeline hazard/forwarding controller.
// Scoreboard entries carry a widened rd so any register-file size up to RD_MAX bits fits.
package pipe_hazard_pkg;

  localparam int RD_MAX = 8;
  localparam int FWD_RF = 0;
  localparam int FWD_M1 = 1;

  typedef struct packed {
    logic              valid;
    logic [RD_MAX-1:0] rd;
    logic              regwrite;
    logic              load;
  } sb_entry_t;

  function automatic int fwd_w(input int memStages);
    return memStages + 1;
  endfunction

  // x0 is hard-wired zero, so it can never be a producer.
  function automatic logic sbMatch(input sb_entry_t e, input logic [RD_MAX-1:0] src);
    return e.valid && e.regwrite && (e.rd != '0) && (e.rd == src);
  endfunction

endpackage

// File: rtl/hz_sb_stage.sv
// One scoreboard entry: holds on freeze, loads a bubble when asked, else takes its input.
module hz_sb_stage
  import pipe_hazard_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      hold,
  input  logic      bubble,
  input  sb_entry_t dIn,
  output sb_entry_t q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      q <= '0;
    else if (!hold) q <= bubble ? '0 : dIn;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall, flush and forwarding control driven by a shadow scoreboard of E, M1..Mn and W.
// Index 0 is E, index k is Mk, index MEM_STAGES+1 is W, matching the forward encoding.
module pipe_hazard_ctrl
  import pipe_hazard_pkg::*;
#(
  parameter int REG_BITS   = 5,
  parameter int MEM_STAGES = 1,
  parameter int FWD_BITS   = 3,
  parameter int CNT_BITS   = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid_d,
  input  logic [REG_BITS-1:0] rs1_d,
  input  logic [REG_BITS-1:0] rs2_d,
  input  logic [REG_BITS-1:0] rd_d,
  input  logic                regwrite_d,
  input  logic                load_d,
  input  logic                pcsrc_e,
  input  logic                mem_busy,
  output logic                stall_f,
  output logic                stall_d,
  output logic                flush_d,
  output logic                flush_e,
  output logic                freeze,
  output logic [FWD_BITS-1:0] fwd_a_e,
  output logic [FWD_BITS-1:0] fwd_b_e,
  output logic [CNT_BITS-1:0] stall_cnt
);

  localparam int W_IDX = fwd_w(MEM_STAGES);
  localparam int NSTG  = W_IDX + 1;

  sb_entry_t         sbQ [NSTG];
  sb_entry_t         dEntry;
  logic [RD_MAX-1:0] rs1D, rs2D, rs1E, rs2E;
  logic              rstDone, busy, pcsrc, ldStall, ldStallG, flushE;
  logic [FWD_BITS-1:0] fwdA, fwdB;

  assign rs1D   = RD_MAX'(rs1_d);
  assign rs2D   = RD_MAX'(rs2_d);
  assign dEntry = '{valid: valid_d, rd: RD_MAX'(rd_d), regwrite: regwrite_d, load: load_d};

  // Outputs stay quiet until the first clock edge after reset release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rstDone <= 1'b0;
    else       rstDone <= 1'b1;
  end

  assign busy     = mem_busy & rstDone;
  assign pcsrc    = pcsrc_e & rstDone;
  assign ldStallG = ldStall & rstDone;
  assign flushE   = (ldStallG | pcsrc) & ~busy;

  assign stall_f = ldStallG | busy;
  assign stall_d = ldStallG | busy;
  assign flush_d = pcsrc & ~busy;
  assign flush_e = flushE;
  assign freeze  = busy;
  assign fwd_a_e = fwdA;
  assign fwd_b_e = fwdB;

  for (genvar k = 0; k < NSTG; k++) begin : gStage
    if (k == 0) begin : gE
      hz_sb_stage uStage (.clk(clk), .reset(reset), .hold(busy), .bubble(flushE),
                          .dIn(dEntry), .q(sbQ[k]));
    end else begin : gMW
      hz_sb_stage uStage (.clk(clk), .reset(reset), .hold(busy), .bubble(1'b0),
                          .dIn(sbQ[k-1]), .q(sbQ[k]));
    end
  end

  // Source addresses of the E instruction, tracked alongside the E entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rs1E <= '0;
      rs2E <= '0;
    end else if (!busy) begin
      rs1E <= flushE ? '0 : rs1D;
      rs2E <= flushE ? '0 : rs2D;
    end
  end

  always_comb begin
    ldStall = 1'b0;
    for (int k = 0; k < MEM_STAGES; k++) begin
      if (sbQ[k].load && (sbMatch(sbQ[k], rs1D) || sbMatch(sbQ[k], rs2D))) ldStall = 1'b1;
    end
    ldStall = ldStall & valid_d;
  end

  // Walk from W toward M1 so the youngest matching producer is applied last.
  always_comb begin
    fwdA = FWD_BITS'(FWD_RF);
    fwdB = FWD_BITS'(FWD_RF);
    for (int k = NSTG - 1; k >= 1; k--) begin
      if (!(sbQ[k].load && k < MEM_STAGES)) begin
        if (sbMatch(sbQ[k], rs1E)) fwdA = FWD_BITS'(FWD_M1 + k - 1);
        if (sbMatch(sbQ[k], rs2E)) fwdB = FWD_BITS'(FWD_M1 + k - 1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_cnt <= '0;
    else if ((stall_f | flushE) && (stall_cnt != '1))
      stall_cnt <= stall_cnt + 1'b1;
  end

endmodule
